fetch_ctrl: RTL

Instruction-fetch controller that owns the program counter and sequences it against a request/response instruction memory. It selects the next PC by priority: trap vector, then branch/jump redirect, then PC+4. It keeps at most one memory request outstanding, discards stale responses after a redirect, and presents one fetched instruction at a time to decode through a valid/ready handshake.

---
 rtl/fetch_ctrl.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/fetch_ctrl.sv
// Instruction-fetch controller: owns the PC, keeps one imem request in flight,
// drops stale responses after a redirect and hands one instruction at a time to decode.
module fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_addr,
  input  logic        trap_valid,
  input  logic [31:0] trap_vec,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_fault,
  output logic [31:0] fetch_cnt
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] cnt_q, cnt_d;
  logic        kill_q, kill_d;
  logic        fault_q, fault_d;

  logic        redir;
  logic [31:0] tgt;
  logic        tgt_mis;
  logic        accept;

  assign redir   = trap_valid | redirect_valid;
  assign tgt     = trap_valid ? trap_vec : redirect_addr;
  assign tgt_mis = |tgt[1:0];

  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = pc_q;
  // Decode must never take a wrong-path entry in the cycle a redirect arrives.
  assign if_valid       = (state_q == HOLD) & ~redir;
  assign if_pc          = pc_q;
  assign if_instr       = (state_q == HOLD) ? instr_q : '0;
  assign if_fault       = (state_q == HOLD) & fault_q;
  assign fetch_cnt      = cnt_q;
  assign accept         = if_valid & if_ready;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    instr_d = instr_q;
    cnt_d   = cnt_q;
    kill_d  = kill_q;
    fault_d = fault_q;
    unique case (state_q)
      IDLE, HOLD: begin
        if (redir) begin
          pc_d = tgt;
          if (tgt_mis) begin
            state_d = HOLD;
            fault_d = 1'b1;
            instr_d = NOP_INSTR;
          end else begin
            state_d = REQ;
          end
        end else if (state_q == IDLE) begin
          state_d = REQ;
        end else if (accept) begin
          pc_d    = pc_q + 32'd4;
          cnt_d   = cnt_q + 32'd1;
          state_d = REQ;
        end
      end
      REQ: begin
        if (redir) begin
          pc_d = tgt;
          if (imem_req_ready) begin
            // The old-address request was already accepted; its response is stale.
            state_d = WAIT;
            kill_d  = 1'b1;
          end else if (tgt_mis) begin
            state_d = HOLD;
            fault_d = 1'b1;
            instr_d = NOP_INSTR;
          end
        end else if (imem_req_ready) begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redir) begin
          pc_d = tgt;
          if (imem_rsp_valid) begin
            kill_d = 1'b0;
            if (tgt_mis) begin
              state_d = HOLD;
              fault_d = 1'b1;
              instr_d = NOP_INSTR;
            end else begin
              state_d = REQ;
            end
          end else begin
            kill_d = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (kill_q) begin
            kill_d = 1'b0;
            // A misaligned redirect seen while waiting is resolved once the bus is free.
            if (|pc_q[1:0]) begin
              state_d = HOLD;
              fault_d = 1'b1;
              instr_d = NOP_INSTR;
            end else begin
              state_d = REQ;
            end
          end else begin
            state_d = HOLD;
            fault_d = 1'b0;
            instr_d = imem_rsp_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= RESET_PC;
      kill_q  <= 1'b0;
      fault_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      fault_q <= fault_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    instr_q <= instr_d;
  end

endmodule
